// File: rtl/cache_fill_ctrl_pkg.sv
// Shared definitions for the direct-mapped cache fill controller.
package cache_fill_ctrl_pkg;

  localparam int ADDR_W    = 16;
  localparam int IDX_W     = 5;
  localparam int OFF_W     = 3;
  localparam int TAG_W     = ADDR_W - IDX_W - OFF_W - 1;
  localparam int NUM_LINES = 1 << IDX_W;

  // Byte address layout: {tag, idx, word, byte}
  localparam int OFF_LSB = 1;
  localparam int IDX_LSB = OFF_LSB + OFF_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_COMMIT
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[TAG_LSB +: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[IDX_LSB +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
    return a[OFF_LSB +: OFF_W];
  endfunction

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// CPU / data-array / memory signal bundle for the fill controller.
interface cache_fill_ctrl_if;
  import cache_fill_ctrl_pkg::*;

  logic                 cpu_req;
  logic                 cpu_we;
  logic [ADDR_W-1:0]    cpu_addr;
  logic                 flush;
  logic                 hit;
  logic                 stall;
  logic [NUM_LINES-1:0] line_en;
  logic [OFF_W-1:0]     word_sel;
  logic                 arr_we;
  logic                 arr_src;
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic                 mem_valid;

  // Controller side
  modport master (
    input  cpu_req, cpu_we, cpu_addr, flush, mem_valid,
    output hit, stall, line_en, word_sel, arr_we, arr_src, mem_req, mem_we, mem_addr
  );

  // CPU / memory / array side
  modport slave (
    output cpu_req, cpu_we, cpu_addr, flush, mem_valid,
    input  hit, stall, line_en, word_sel, arr_we, arr_src, mem_req, mem_we, mem_addr
  );

endinterface

// File: rtl/cache_fill_ctrl_convert5to32.sv
// 5-to-32 one-hot line decoder for the data array.
module convert5to32 (
  input  logic [4:0]  idx,
  output logic [31:0] onehot
);

  // One comparator per line select
  for (genvar i = 0; i < 32; i++) begin : g_dec
    assign onehot[i] = (idx == 5'(i));
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Direct-mapped cache controller: valid/tag store, write-through hits,
// no-write-allocate, 8-word line fill on read miss.
module cache_fill_ctrl
  import cache_fill_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  cache_fill_ctrl_if.master bus
);

  state_t               state, state_nxt;
  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags [NUM_LINES];
  logic [ADDR_W-1:0]    miss_addr;
  logic [OFF_W-1:0]     issue_cnt, fill_cnt;
  logic                 flush_pend;

  logic [IDX_W-1:0]     cidx, midx, dec_idx;
  logic                 cpu_hit, latch_miss, fill_evt, commit_evt;

  logic                 hit, stall, arr_we, arr_src, mem_req, mem_we;
  logic [OFF_W-1:0]     word_sel;
  logic [ADDR_W-1:0]    mem_addr;

  assign cidx    = addr_idx(bus.cpu_addr);
  assign midx    = addr_idx(miss_addr);
  assign cpu_hit = bus.cpu_req && valid[cidx] && (tags[cidx] == addr_tag(bus.cpu_addr));

  // Line select follows the CPU in IDLE (and in reset), the miss line otherwise
  assign dec_idx = (state == S_IDLE || rst) ? cidx : midx;

  convert5to32 u_dec (
    .idx    (dec_idx),
    .onehot (bus.line_en)
  );

  // Next state and array/memory strobes
  always_comb begin
    state_nxt  = state;
    hit        = 1'b0;
    stall      = 1'b0;
    arr_we     = 1'b0;
    arr_src    = 1'b0;
    word_sel   = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    latch_miss = 1'b0;
    fill_evt   = 1'b0;
    commit_evt = 1'b0;
    case (state)
      S_IDLE: begin
        hit = cpu_hit;
        if (bus.cpu_req) begin
          if (bus.cpu_we) begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = {bus.cpu_addr[ADDR_W-1:1], 1'b0};
            if (cpu_hit) begin
              arr_we   = 1'b1;
              word_sel = addr_word(bus.cpu_addr);
            end
          end else if (!cpu_hit) begin
            stall      = 1'b1;
            latch_miss = 1'b1;
            state_nxt  = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {miss_addr[ADDR_W-1:IDX_LSB], issue_cnt, 1'b0};
        if (issue_cnt == 3'd7) state_nxt = S_WAIT;
      end
      S_WAIT:   stall = 1'b1;
      S_COMMIT: begin
        stall     = 1'b1;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
    // Returns are counted independently of issues; early ones land during FETCH
    if ((state == S_FETCH || state == S_WAIT) && bus.mem_valid) begin
      arr_we   = 1'b1;
      arr_src  = 1'b1;
      word_sel = fill_cnt;
      fill_evt = 1'b1;
      if (fill_cnt == 3'd7) begin
        commit_evt = 1'b1;
        state_nxt  = S_COMMIT;
      end
    end
    // Keep the CPU and memory quiet while reset is held
    if (rst) begin
      hit      = 1'b0;
      stall    = 1'b0;
      arr_we   = 1'b0;
      arr_src  = 1'b0;
      word_sel = '0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
    end
  end

  assign bus.hit      = hit;
  assign bus.stall    = stall;
  assign bus.arr_we   = arr_we;
  assign bus.arr_src  = arr_src;
  assign bus.word_sel = word_sel;
  assign bus.mem_req  = mem_req;
  assign bus.mem_we   = mem_we;
  assign bus.mem_addr = mem_addr;

  // State, counters, valid bits and deferred flush
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      valid      <= '0;
      issue_cnt  <= '0;
      fill_cnt   <= '0;
      flush_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH) issue_cnt <= issue_cnt + 3'd1;
      if (fill_evt)         fill_cnt  <= fill_cnt + 3'd1;
      // Flush in IDLE clears after this cycle's lookup; otherwise it waits
      if (state == S_IDLE) begin
        flush_pend <= 1'b0;
        if (bus.flush || flush_pend) valid <= '0;
      end else if (bus.flush) begin
        flush_pend <= 1'b1;
      end
      if (commit_evt) valid[midx] <= 1'b1;
    end
  end

  // Miss address and tag store need no reset
  always_ff @(posedge clk) begin
    if (latch_miss) miss_addr  <= bus.cpu_addr;
    if (commit_evt) tags[midx] <= addr_tag(miss_addr);
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl with a fixed-latency memory model.
module tb_cache_fill_ctrl;
  import cache_fill_ctrl_pkg::*;

  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_fill_ctrl_if bus ();

  cache_fill_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // In-order memory: each read request returns mem_valid LAT cycles later
  logic [LAT-1:0] rd_pipe = '0;
  always @(posedge clk) rd_pipe <= {rd_pipe[LAT-2:0], bus.mem_req & ~bus.mem_we};
  assign bus.mem_valid = rd_pipe[LAT-1];

  int n_vec = 0;
  int n_err = 0;
  logic [ADDR_W-1:0] q_addr [$];
  logic [OFF_W-1:0]  q_word [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0234; bus.flush = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.hit, bus.stall, bus.arr_we, bus.arr_src, bus.mem_req, bus.mem_we} !== 6'b0) begin
      n_err++; $display("FAIL reset_strobes got %b exp 000000",
        {bus.hit, bus.stall, bus.arr_we, bus.arr_src, bus.mem_req, bus.mem_we});
    end
    n_vec++;
    if (bus.mem_addr !== 16'h0 || bus.word_sel !== 3'd0) begin
      n_err++; $display("FAIL reset_addr got %h/%0d exp 0000/0", bus.mem_addr, bus.word_sel);
    end
    n_vec++;
    if (bus.line_en !== 32'h0000_0008) begin
      n_err++; $display("FAIL reset_line_en got %h exp 00000008", bus.line_en);
    end
    tick();
  endtask

  // Drive a read miss and scoreboard the whole fill up to the hit cycle.
  // mode 0: plain, 1: flush pulse during WAIT, 2: flush on the miss cycle
  task automatic run_fill(input logic [ADDR_W-1:0] a, input int mode);
    logic [ADDR_W-1:0] ea;
    logic [OFF_W-1:0]  ew;
    logic [31:0]       el;
    bit fl_req, fl_done, done;
    el = 32'h1 << a[8:4];
    for (int i = 0; i < 8; i++) begin
      q_addr.push_back({a[15:4], 3'(i), 1'b0});
      q_word.push_back(3'(i));
    end
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a; bus.flush = (mode == 2);
    @(negedge clk);
    n_vec++;
    if ({bus.hit, bus.stall, bus.arr_we, bus.mem_req} !== 4'b0100) begin
      n_err++; $display("FAIL miss_cycle %h got hit/stall/we/req %b exp 0100", a,
        {bus.hit, bus.stall, bus.arr_we, bus.mem_req});
    end
    fl_req = 0; fl_done = 0; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      tick();
      bus.flush = fl_req;
      fl_req = 0;
      @(negedge clk);
      if (bus.mem_req) begin
        ea = (q_addr.size() > 0) ? q_addr.pop_front() : 16'hFFFF;
        n_vec++;
        if (bus.mem_we !== 1'b0 || bus.mem_addr !== ea) begin
          n_err++; $display("FAIL fill_issue got we=%b addr=%h exp we=0 addr=%h",
            bus.mem_we, bus.mem_addr, ea);
        end
      end
      if (bus.arr_we) begin
        ew = (q_word.size() > 0) ? q_word.pop_front() : 3'bxxx;
        n_vec++;
        if (bus.arr_src !== 1'b1 || bus.word_sel !== ew || bus.line_en !== el) begin
          n_err++; $display("FAIL fill_write got src=%b word=%0d line=%h exp src=1 word=%0d line=%h",
            bus.arr_src, bus.word_sel, bus.line_en, ew, el);
        end
      end
      if (mode == 1 && !fl_done && bus.stall && !bus.mem_req && bus.arr_we) begin
        fl_req = 1; fl_done = 1;
      end
      if (!bus.stall) done = 1;
    end
    n_vec++;
    if (!done || q_addr.size() != 0 || q_word.size() != 0 || bus.hit !== 1'b1 ||
        (mode == 1 && !fl_done)) begin
      n_err++; $display("FAIL fill_end %h got done=%0b left=%0d/%0d hit=%b exp done=1 left=0/0 hit=1",
        a, done, q_addr.size(), q_word.size(), bus.hit);
    end
    q_addr.delete(); q_word.delete();
    tick();
    bus.cpu_req = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic test_fill();
    run_fill(16'h0234, 0);
  endtask

  task automatic test_hit_write();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0236;
    @(negedge clk);
    n_vec++;
    if ({bus.hit, bus.stall, bus.mem_req, bus.arr_we} !== 4'b1000) begin
      n_err++; $display("FAIL read_hit got %b exp 1000", {bus.hit, bus.stall, bus.mem_req, bus.arr_we});
    end
    tick();
    bus.cpu_we = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus.hit, bus.stall, bus.arr_we, bus.arr_src, bus.mem_req, bus.mem_we} !== 6'b101011) begin
      n_err++; $display("FAIL write_hit got %b exp 101011",
        {bus.hit, bus.stall, bus.arr_we, bus.arr_src, bus.mem_req, bus.mem_we});
    end
    n_vec++;
    if (bus.word_sel !== 3'd3 || bus.mem_addr !== 16'h0236 || bus.line_en !== 32'h0000_0008) begin
      n_err++; $display("FAIL write_hit_addr got %0d/%h/%h exp 3/0236/00000008",
        bus.word_sel, bus.mem_addr, bus.line_en);
    end
    tick();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
  endtask

  task automatic test_write_miss();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h4450;
    @(negedge clk);
    n_vec++;
    if ({bus.hit, bus.stall, bus.arr_we, bus.mem_req, bus.mem_we} !== 5'b00011 ||
        bus.mem_addr !== 16'h4450) begin
      n_err++; $display("FAIL write_miss got %b/%h exp 00011/4450",
        {bus.hit, bus.stall, bus.arr_we, bus.mem_req, bus.mem_we}, bus.mem_addr);
    end
    tick();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    run_fill(16'h4450, 0);
  endtask

  task automatic test_conflict();
    run_fill(16'h1234, 0);
    run_fill(16'h0234, 0);
  endtask

  task automatic test_flush();
    run_fill(16'h1234, 1);
    run_fill(16'h1234, 0);
    // Flush in IDLE: this cycle still hits, next access misses
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234; bus.flush = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus.hit, bus.stall} !== 2'b10) begin
      n_err++; $display("FAIL idle_flush_lookup got %b exp 10", {bus.hit, bus.stall});
    end
    tick();
    bus.flush = 1'b0; bus.cpu_req = 1'b0;
    run_fill(16'h1234, 0);
  endtask

  task automatic test_back_to_back();
    // Flush with a read miss: old lines go, the new one is committed valid
    run_fill(16'h4450, 2);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h4450;
    @(negedge clk);
    n_vec++;
    if ({bus.hit, bus.stall} !== 2'b10) begin
      n_err++; $display("FAIL flush_miss_new_line got %b exp 10", {bus.hit, bus.stall});
    end
    tick();
    bus.cpu_req = 1'b0;
    run_fill(16'h1234, 0);
  endtask

  task automatic test_reset_mid_fill();
    int nreq, nlate;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0550;
    @(negedge clk);
    nreq = 0;
    for (int k = 0; k < 20 && nreq < 4; k++) begin
      tick();
      @(negedge clk);
      if (bus.mem_req) nreq++;
    end
    tick();
    rst = 1'b1; bus.cpu_req = 1'b0;
    tick();
    rst = 1'b0;
    nlate = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.mem_valid) nlate++;
      n_vec++;
      if (bus.arr_we !== 1'b0 || bus.stall !== 1'b0) begin
        n_err++; $display("FAIL late_return got arr_we=%b stall=%b exp 0/0", bus.arr_we, bus.stall);
      end
      tick();
    end
    n_vec++;
    if (nreq != 4 || nlate == 0) begin
      n_err++; $display("FAIL reset_scenario got reqs=%0d late=%0d exp reqs=4 late>0", nreq, nlate);
    end
    run_fill(16'h0234, 0);
  endtask

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.flush = 1'b0;
    test_reset();
    test_fill();
    test_hit_write();
    test_write_miss();
    test_conflict();
    test_flush();
    test_back_to_back();
    test_reset_mid_fill();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
- Controller for the 32-line direct-mapped cache.
- Owns the valid bits and tags. Sequences line fills from main memory on read misses. Drives the data array's one-hot line enable through the 5-to-32 index decoder.
- Write-through, no-write-allocate. Sits between the CPU memory stage and the memory interface.

Parameters:
- ADDR_W, 16, byte address width.
- IDX_W, 5, line index width (32 lines; fixed by the decoder).
- OFF_W, 3, word offset width (8 x 16-bit words per line).
- TAG_W, 7, tag width (ADDR_W - IDX_W - OFF_W - 1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cpu_req  in  1  CPU access valid this cycle.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  byte address; tag = [15:9], idx = [8:4], word = [3:1], bit 0 ignored.
- flush  in  1  invalidate all lines (pulse).
- hit  out  1  access hits a valid line (combinational, IDLE only).
- stall  out  1  CPU must hold its request.
- line_en  out  32  one-hot data-array line select.
- word_sel  out  OFF_W  data-array word select.
- arr_we  out  1  data-array write strobe.
- arr_src  out  1  write data source: 0 = CPU, 1 = memory.
- mem_req  out  1  memory request; accepted every cycle.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory word address, bit 0 = 0.
- mem_valid  in  1  read data returning; in order, fixed latency.

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high on rst. Port names are clk/rst.
- Reset (and reset mid-fill): state=IDLE; all 32 valid bits cleared; tags are don't-care; issue_cnt=fill_cnt=0; flush_pend=0. All outputs are 0 except line_en, which decodes idx of cpu_addr.
- Stray returns: mem_valid arriving in IDLE or COMMIT is ignored, including late returns after reset.
- States: IDLE, FETCH, WAIT, COMMIT.
- IDLE:
  - hit = cpu_req & valid[idx] & (tag[idx]==addr tag).
  - Read hit: stall=0. Zero-cycle access; data array read by the datapath.
  - Write hit: arr_we=1, arr_src=0, word_sel=addr word, line_en=decode(idx). Same cycle: mem_req=1, mem_we=1, mem_addr=cpu_addr. stall=0.
  - Write miss: memory write only; no array write, valid unchanged. stall=0.
  - Read miss: stall=1. Latch miss_addr. Go to FETCH.
- FETCH:
  - Each cycle: mem_req=1, mem_we=0, mem_addr={miss tag, miss idx, issue_cnt, 1'b0}; issue_cnt++.
  - After the issue_cnt=7 request, go to WAIT.
  - Exactly 8 requests on 8 consecutive cycles.
- FETCH and WAIT, on each mem_valid:
  - arr_we=1, arr_src=1, word_sel=fill_cnt, line_en=decode(miss idx); fill_cnt++.
  - On mem_valid with fill_cnt=7: valid[idx]=1, tag[idx]=miss tag at that edge; go to COMMIT.
  - mem_valid may arrive while still in FETCH (latency < 8); the return counter is independent of the issue counter.
- COMMIT: stall=1 for one cycle, then IDLE. The held request now hits.
- Stall: stall=1 throughout FETCH/WAIT/COMMIT. cpu_* ignored there; the latched miss_addr is used.
- Miss penalty: 8 + LAT + 1 cycles from the miss cycle to the hit cycle.
- Flush:
  - In IDLE: all valid bits cleared at the next edge; any access that cycle is evaluated against the pre-flush state.
  - Outside IDLE: sets flush_pend; applied on the first IDLE cycle after COMMIT, so the just-filled line is also invalidated.
- Simultaneous flush + read miss in IDLE: the fill proceeds and the flush clears the old state. The new line's valid bit is then set by the commit.
- Counters are 3 bits and wrap 7->0. No other arithmetic.

Decomposition:
- Shared cache package: ADDR_W, IDX_W, OFF_W, TAG_W, state encoding, and address field-slice constants.
- One sub-module: the existing 5-to-32 decoder (convert5to32), instanced once on a muxed index (cpu idx in IDLE, miss idx otherwise) to drive line_en.

Test Plan:
- Reset, then read 0x0234 -> hit=0, stall=1. mem_addr 0x0230..0x023E issued in 8 consecutive cycles. Eight arr_we pulses with word_sel 0..7 and line_en=0x00000008. COMMIT, then hit=1, stall=0.
- Read 0x0236 after fill -> hit=1, stall=0, no mem_req. Write 0x0236 -> arr_we=1, arr_src=0, word_sel=3, mem_we=1, mem_addr=0x0236.
- Write miss 0x4450 -> mem_req=1, mem_we=1, arr_we=0, stall=0. Subsequent read 0x4450 misses.
- Conflict: fill 0x0234, then read 0x1234 (same idx 3, tag 9) -> miss; refill; re-read 0x0234 -> miss.
- Flush asserted during WAIT -> fill completes. First IDLE cycle after COMMIT clears all valid bits; a read of the filled line then misses.
- rst asserted mid-FETCH at issue_cnt=4 -> next cycle IDLE, valid all 0. Late mem_valid pulses cause no arr_we.
